// File: rtl/lsu_dmem_port_if.sv
// Request, data-memory and completion signals shared by the LSU data-memory port
// and whatever sits on the pipeline/memory side of it.
interface lsu_dmem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_w_en;
  logic        mem_r_en;
  logic [31:0] mem_addr;
  logic [2:0]  mem_rw_type;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_dout, resp_ready,
    output req_ready, mem_w_en, mem_r_en, mem_addr, mem_rw_type, mem_din,
    output resp_valid, resp_rdata, resp_rd, exc_valid, exc_cause, exc_tval
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, mem_dout, resp_ready,
    input  req_ready, mem_w_en, mem_r_en, mem_addr, mem_rw_type, mem_din,
    input  resp_valid, resp_rdata, resp_rd, exc_valid, exc_cause, exc_tval
  );
endinterface

// File: rtl/lsu_dmem_port.sv
// Single-outstanding load/store port between the MEM stage and data memory.
// Requests are classified on acceptance; faults skip the memory access entirely.
module lsu_dmem_port #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  output logic              o_busy,
  lsu_dmem_port_if.slave    bus
);

  // state  | meaning
  // IDLE   | waiting for a request
  // ACCESS | one-cycle memory enable for a legal request
  // RESP   | completion (or exception) held until writeback takes it
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [31:0] WORD_LIMIT = 32'(DMEM_WORDS);

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [31:0] r_resp_rdata;
  logic        r_exc_valid;
  logic [3:0]  r_exc_cause;

  logic        w_kill;
  logic        w_req_ready;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic [3:0]  w_cause;
  logic        w_fault;
  logic        w_in_access;

  assign w_kill      = i_reset | i_flush;
  assign w_req_ready = (r_state == ST_IDLE) & ~w_kill;
  assign w_accept    = bus.req_valid & w_req_ready;

  assign w_illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                                : (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 ||
                                   bus.req_funct3 == 3'd7);
  // funct3[1:0] encodes size for every legal code: 0 byte, 1 half, 2 word
  assign w_misaligned = ((bus.req_funct3[1:0] == 2'd1) & bus.req_addr[0]) |
                        ((bus.req_funct3[1:0] == 2'd2) & (bus.req_addr[1:0] != 2'b00));
  assign w_out_of_range = {2'b00, bus.req_addr[31:2]} >= WORD_LIMIT;

  always_comb begin
    w_cause = 4'd0;
    if (w_illegal)           w_cause = 4'd2;
    else if (w_misaligned)   w_cause = bus.req_we ? 4'd6 : 4'd4;
    else if (w_out_of_range) w_cause = bus.req_we ? 4'd7 : 4'd5;
  end

  assign w_fault = (w_cause != 4'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rd         <= 5'd0;
      r_resp_rdata <= 32'd0;
      r_exc_valid  <= 1'b0;
      r_exc_cause  <= 4'd0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we         <= bus.req_we;
            r_funct3     <= bus.req_funct3;
            r_addr       <= bus.req_addr;
            r_wdata      <= bus.req_wdata;
            r_rd         <= bus.req_rd;
            r_resp_rdata <= 32'd0;
            r_exc_valid  <= w_fault;
            r_exc_cause  <= w_cause;
            r_state      <= w_fault ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_we) r_resp_rdata <= bus.mem_dout;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_in_access = (r_state == ST_ACCESS);

  assign bus.req_ready   = w_req_ready;
  assign bus.mem_w_en    = w_in_access & r_we & ~w_kill;
  assign bus.mem_r_en    = w_in_access & ~r_we & ~w_kill;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_rw_type = r_funct3;
  assign bus.mem_din     = r_wdata;

  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_rd    = (r_we | r_exc_valid) ? 5'd0 : r_rd;
  assign bus.exc_valid  = r_exc_valid;
  assign bus.exc_cause  = r_exc_cause;
  // an illegal-instruction completion carries no address
  assign bus.exc_tval   = (r_exc_valid && r_exc_cause != 4'd2) ? r_addr : 32'd0;

  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Bench for lsu_dmem_port: transaction-level reference model checked every cycle,
// directed literal cases, then randomized traffic with flush/reset/backpressure.
module tb_lsu_dmem_port;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  lsu_dmem_port_if bus ();

  lsu_dmem_port #(.DMEM_WORDS(1024)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_flush(flush),
    .o_busy (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_words [0:1023];

  function automatic logic [31:0] lane_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = 16'(w >> (16 * a[1]));
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  always_comb bus.mem_dout = lane_ext(mem_words[bus.mem_addr[11:2]], bus.mem_addr[1:0],
                                      bus.mem_rw_type);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Exception cause from the access rules; 0 means legal.
  function automatic logic [3:0] classify(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
    int size;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (we ? (f3 > 3'd2) : (size == 0)) return 4'd2;
    if (addr % size != 0) return we ? 4'd6 : 4'd4;
    if ((addr >> 2) >= 1024) return we ? 4'd7 : 4'd5;
    return 4'd0;
  endfunction

  // Model: at most one transaction, tracked by edges elapsed since acceptance.
  logic        m_on = 1'b0;
  logic        m_act, m_legal, m_we;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_rdata;
  logic [4:0]  m_rd;
  logic [3:0]  m_cause;
  int          m_age;
  logic [31:0] l_addr, l_wdata;
  logic [2:0]  l_f3;
  logic        e_rv;

  function automatic logic resp_due();
    return m_act && (m_legal ? (m_age >= 2) : (m_age >= 1));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_act = 1'b0; l_addr = '0; l_wdata = '0; l_f3 = '0;
    end else if (flush) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (bus.req_valid) begin
        m_act   = 1'b1;
        m_age   = 1;
        m_we    = bus.req_we;
        m_f3    = bus.req_funct3;
        m_addr  = bus.req_addr;
        m_rd    = bus.req_rd;
        m_cause = classify(bus.req_we, bus.req_funct3, bus.req_addr);
        m_legal = (m_cause == 4'd0);
        m_rdata = (m_legal && !m_we) ? lane_ext(mem_words[m_addr[11:2]], m_addr[1:0], m_f3) : 32'd0;
        l_addr  = bus.req_addr;
        l_wdata = bus.req_wdata;
        l_f3    = bus.req_funct3;
      end
    end else if (resp_due() && bus.resp_ready) begin
      m_act = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      e_rv = resp_due();
      chk("req_ready", 32'(bus.req_ready), 32'(!m_act && !rst && !flush));
      chk("busy", 32'(busy), 32'(m_act));
      chk("mem_w_en", 32'(bus.mem_w_en), 32'(m_act && m_legal && m_age == 1 && m_we && !rst && !flush));
      chk("mem_r_en", 32'(bus.mem_r_en), 32'(m_act && m_legal && m_age == 1 && !m_we && !rst && !flush));
      chk("mem_addr", bus.mem_addr, l_addr);
      chk("mem_rw_type", 32'(bus.mem_rw_type), 32'(l_f3));
      chk("mem_din", bus.mem_din, l_wdata);
      chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("exc_valid", 32'(bus.exc_valid), 32'(!m_legal));
        chk("resp_rd", 32'(bus.resp_rd), (m_legal && !m_we) ? 32'(m_rd) : 32'd0);
        if (m_legal) begin
          chk("resp_rdata", bus.resp_rdata, m_rdata);
        end else begin
          chk("exc_cause", 32'(bus.exc_cause), 32'(m_cause));
          chk("exc_tval", bus.exc_tval, (m_cause == 4'd2) ? 32'd0 : m_addr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    step();
    bus.req_valid  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_words[i] = $urandom;
    mem_words[4] = 32'h8012_3456;
    mem_words[8] = 32'hCAFE_F00D;
    mem_words[9] = 32'h1234_5678;
    rst = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0; bus.resp_ready = 1'b1;
    step(); step();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    m_on = 1'b1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 5'd3);
    chk("sw_wen", 32'(bus.mem_w_en), 32'd1);
    chk("sw_ren", 32'(bus.mem_r_en), 32'd0);
    chk("sw_addr", bus.mem_addr, 32'h10);
    chk("sw_type", 32'(bus.mem_rw_type), 32'd2);
    chk("sw_din", bus.mem_din, 32'hDEAD_BEEF);
    step();
    chk("sw_wen_off", 32'(bus.mem_w_en), 32'd0);
    chk("sw_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("sw_rd", 32'(bus.resp_rd), 32'd0);
    chk("sw_exc", 32'(bus.exc_valid), 32'd0);
    step();

    issue(1'b0, 3'd0, 32'h13, 32'd0, 5'd5);
    chk("lb_ren", 32'(bus.mem_r_en), 32'd1);
    step();
    chk("lb_rdata", bus.resp_rdata, 32'hFFFF_FF80);
    chk("lb_rd", 32'(bus.resp_rd), 32'd5);
    step();

    issue(1'b0, 3'd1, 32'h11, 32'd0, 5'd7);
    chk("lh_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("lh_exc", 32'(bus.exc_valid), 32'd1);
    chk("lh_cause", 32'(bus.exc_cause), 32'd4);
    chk("lh_tval", bus.exc_tval, 32'h11);
    chk("lh_ren", 32'(bus.mem_r_en), 32'd0);
    step();

    issue(1'b1, 3'd2, 32'h1000, 32'd1, 5'd0);
    chk("swoob_cause", 32'(bus.exc_cause), 32'd7);
    chk("swoob_wen", 32'(bus.mem_w_en), 32'd0);
    step();

    issue(1'b0, 3'd3, 32'h40, 32'd0, 5'd2);
    chk("ill_cause", 32'(bus.exc_cause), 32'd2);
    chk("ill_tval", bus.exc_tval, 32'd0);
    step();

    bus.resp_ready = 1'b0;
    issue(1'b0, 3'd2, 32'h20, 32'd0, 5'd9);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_rdata", bus.resp_rdata, 32'hCAFE_F00D);
      chk("bp_rd", 32'(bus.resp_rd), 32'd9);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    chk("bp_idle_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 3'd2, 32'h24, 32'd0, 5'd1);
    chk("bp_next_ren", 32'(bus.mem_r_en), 32'd1);
    step();
    chk("bp_next_rdata", bus.resp_rdata, 32'h1234_5678);
    step();

    issue(1'b1, 3'd2, 32'h30, 32'h55AA_55AA, 5'd0);
    flush = 1'b1;
    #1;
    chk("fl_wen", 32'(bus.mem_w_en), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("fl_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 3'd2, 32'h24, 32'd0, 5'd6);
    step();
    chk("fl_lw_rdata", bus.resp_rdata, 32'h1234_5678);
    chk("fl_lw_rd", 32'(bus.resp_rd), 32'd6);
    step();

    issue(1'b0, 3'd2, 32'h24, 32'd0, 5'd4);
    rst = 1'b1;
    #1;
    chk("rs_ren", 32'(bus.mem_r_en), 32'd0);
    chk("rs_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_ready_after", 32'(bus.req_ready), 32'd1);
    chk("rs_addr", bus.mem_addr, 32'd0);
    step();

    for (int n = 0; n < 4000; n++) begin
      bus.req_valid  = ($urandom_range(0, 2) != 0);
      bus.req_we     = 1'($urandom_range(0, 1));
      bus.req_funct3 = ($urandom_range(0, 9) > 7) ? 3'd2 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       bus.req_addr = 32'($urandom_range(0, 4095));
        1:       bus.req_addr = 32'($urandom_range(0, 4095)) & 32'hFFFF_FFFC;
        2:       bus.req_addr = $urandom;
        default: bus.req_addr = 32'($urandom_range(32'hFF8, 32'h1007));
      endcase
      bus.req_wdata  = $urandom;
      bus.req_rd     = 5'($urandom_range(0, 31));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 39) == 0);
      rst            = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
